ofs_plat_host_chan_rd_tag_tracker: RTL and testbench
====================================================

Name: ofs_plat_host_chan_rd_tag_tracker

Overview:
- Parametrised PCIe read-tag manager between the AFU read-request path and the TX TLP generator.
- Allocates an internal PCIe tag per multi-line AFU read and records the AFU tag and line count.
- Matches returning per-line completions to the tag and emits AFU read responses with line_idx/last.
- Frees the tag on the final line. Generalises fixed-width read tracking to configurable tag count, line count and payload width, and adds error reporting.

Parameters:
- NUM_TAGS, 64, number of PCIe tags in flight (power of 2, 2..256); TAG_W = $clog2(NUM_TAGS).
- AFU_TAG_WIDTH, 16, width of the AFU tag.
- MAX_LINES, 4, maximum lines per request (power of 2); LC_W = $clog2(MAX_LINES)+1, IDX_W = max(1,$clog2(MAX_LINES)).
- PAYLOAD_LINE_SIZE, 512, bits per line.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  AFU read request valid
- req_ready  out  1  request accepted when valid&ready
- req_afu_tag  in  AFU_TAG_WIDTH  AFU tag
- req_line_count  in  LC_W  lines requested, legal range 1..MAX_LINES
- req_addr  in  64  line-aligned byte address
- tlp_valid  out  1  TLP request to generator valid
- tlp_ready  in  1  generator accepts
- tlp_tag  out  TAG_W  allocated PCIe tag
- tlp_line_count  out  LC_W  copy of request line count
- tlp_addr  out  64  copy of request address
- cpl_valid  in  1  one completion line valid
- cpl_ready  out  1  completion accepted
- cpl_tag  in  TAG_W  PCIe tag of completion
- cpl_payload  in  PAYLOAD_LINE_SIZE  line data
- rsp_valid  out  1  AFU response valid
- rsp_ready  in  1  AFU accepts
- rsp_afu_tag  out  AFU_TAG_WIDTH  original AFU tag
- rsp_line_idx  out  IDX_W  zero-based line index
- rsp_last  out  1  final line of request
- rsp_payload  out  PAYLOAD_LINE_SIZE  line data
- busy_tags  out  TAG_W+1  tags currently allocated
- err_bad_len  out  1  sticky: illegal line count seen
- err_unexp_cpl  out  1  sticky: completion to a free tag

Behaviour:
- Reset (async, reset_n=0): all tags free, all per-tag line counters 0, tlp_valid=0, rsp_valid=0, busy_tags=0, both error flags 0. req_ready and cpl_ready are combinational and evaluate to 1 after reset.
- Per-tag state: in_use bit, afu_tag, line_count, rx_count (IDX_W+1 bits).
- Allocation:
  - req_ready = (any tag free) && (!tlp_valid || tlp_ready).
  - On accept, pick the lowest-index free tag from the start-of-cycle state. Set in_use, store fields, clear rx_count.
  - Register tlp_* next cycle: 1-cycle latency. Skid-free output register; holds stable while tlp_valid && !tlp_ready.
- Illegal length: line_count==0 or >MAX_LINES is accepted (req_ready per rule above), dropped with no tag allocated and no TLP, and sets err_bad_len.
- Completion: cpl_ready = !rsp_valid || rsp_ready. Lines within a tag arrive in address order.
  - On accept with in_use[cpl_tag]=1, next cycle drive rsp_* with rsp_line_idx=rx_count, rsp_last=(rx_count==line_count-1), payload passed through; increment rx_count.
  - On the last line, clear in_use at the same edge. The tag becomes allocatable from the following cycle.
  - Completion to a free tag: dropped, no response, err_unexp_cpl set.
- Simultaneous allocate and free in the same cycle: allocation uses pre-free state, so the freed tag is never re-issued that cycle; busy_tags nets +1-1=0.
- Full: busy_tags==NUM_TAGS gives req_ready=0. Completions still drain.
- Error flags clear only on reset.
- Mid-operation reset discards all outstanding state; completions arriving after reset count as unexpected.

Test Plan:
- Single request afu_tag=0x1234, line_count=4, addr=0x1000 -> tlp_valid next cycle, tlp_tag=0; 4 cpl on tag 0 -> rsp line_idx 0,1,2,3, rsp_last only on idx 3, afu_tag 0x1234; busy_tags returns to 0.
- NUM_TAGS=4: issue 4 one-line requests -> tags 0..3, req_ready=0, busy_tags=4; complete tag 2 -> next request gets tag 2.
- Interleaved completions tag1 L0, tag0 L0, tag1 L1 (both line_count=2) -> rsp order preserved, tag1 last on its L1, tag0 still busy.
- rsp_ready held 0 for 5 cycles with cpl pending -> cpl_ready=0, rsp_* stable, no data loss; tlp_ready=0 -> tlp_* stable, req_ready=0.
- Request line_count=0 and line_count=MAX_LINES+1 -> no TLP, err_bad_len=1; cpl to free tag 5 -> no rsp, err_unexp_cpl=1.
- Full table, then last line of tag 3 and new request in the same cycle -> request stalls that cycle, gets tag 3 next cycle; reset_n pulsed mid-burst -> all outputs 0, flags cleared.

Source files
------------

// File: rtl/ofs_plat_host_chan_rd_tag_tracker.sv
// PCIe read-tag tracker between the AFU read-request path and the TLP generator.
// Each legal AFU read gets the lowest free PCIe tag. Per-line completions are
// matched back to the AFU tag and emitted with a line index and a last flag.
module ofs_plat_host_chan_rd_tag_tracker #(
    parameter int unsigned NUM_TAGS          = 64,
    parameter int unsigned AFU_TAG_WIDTH     = 16,
    parameter int unsigned MAX_LINES         = 4,
    parameter int unsigned PAYLOAD_LINE_SIZE = 512,
    localparam int unsigned TAG_W            = $clog2(NUM_TAGS),
    localparam int unsigned LC_W             = $clog2(MAX_LINES) + 1,
    localparam int unsigned IDX_W            = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,

    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [AFU_TAG_WIDTH-1:0]     req_afu_tag,
    input  logic [LC_W-1:0]              req_line_count,
    input  logic [63:0]                  req_addr,

    output logic                         tlp_valid,
    input  logic                         tlp_ready,
    output logic [TAG_W-1:0]             tlp_tag,
    output logic [LC_W-1:0]              tlp_line_count,
    output logic [63:0]                  tlp_addr,

    input  logic                         cpl_valid,
    output logic                         cpl_ready,
    input  logic [TAG_W-1:0]             cpl_tag,
    input  logic [PAYLOAD_LINE_SIZE-1:0] cpl_payload,

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [AFU_TAG_WIDTH-1:0]     rsp_afu_tag,
    output logic [IDX_W-1:0]             rsp_line_idx,
    output logic                         rsp_last,
    output logic [PAYLOAD_LINE_SIZE-1:0] rsp_payload,

    output logic [TAG_W:0]               busy_tags,
    output logic                         err_bad_len,
    output logic                         err_unexp_cpl
);

    localparam int unsigned RX_W   = IDX_W + 1;
    localparam int unsigned CMP_W  = (LC_W > RX_W) ? LC_W : RX_W;
    localparam int unsigned BUSY_W = TAG_W + 1;

    // Per-tag tracking state
    logic [NUM_TAGS-1:0]      in_use_q;
    logic [AFU_TAG_WIDTH-1:0] afu_tag_q    [NUM_TAGS];
    logic [LC_W-1:0]          line_count_q [NUM_TAGS];
    logic [RX_W-1:0]          rx_count_q   [NUM_TAGS];

    // Output registers
    logic                         tlp_valid_q,      tlp_valid_d;
    logic [TAG_W-1:0]             tlp_tag_q,        tlp_tag_d;
    logic [LC_W-1:0]              tlp_line_count_q, tlp_line_count_d;
    logic [63:0]                  tlp_addr_q,       tlp_addr_d;
    logic                         rsp_valid_q,      rsp_valid_d;
    logic [AFU_TAG_WIDTH-1:0]     rsp_afu_tag_q,    rsp_afu_tag_d;
    logic [IDX_W-1:0]             rsp_line_idx_q,   rsp_line_idx_d;
    logic                         rsp_last_q,       rsp_last_d;
    logic [PAYLOAD_LINE_SIZE-1:0] rsp_payload_q,    rsp_payload_d;
    logic [BUSY_W-1:0]            busy_q,           busy_d;
    logic                         err_bad_len_q,    err_bad_len_d;
    logic                         err_unexp_cpl_q,  err_unexp_cpl_d;

    // Request-side decode
    logic              any_free;
    logic [TAG_W-1:0]  alloc_tag;
    logic              tlp_slot_free;
    logic              req_fire;
    logic              len_ok;
    logic              do_alloc;
    logic              do_bad_len;

    // Completion-side decode
    logic              cpl_fire;
    logic              cpl_hit;
    logic              cpl_miss;
    logic [RX_W-1:0]   cur_rx;
    logic [LC_W-1:0]   cur_lc;
    logic              cpl_last;
    logic              do_free;

    assign any_free      = ~&in_use_q;
    assign tlp_slot_free = !tlp_valid_q || tlp_ready;
    assign req_ready     = any_free && tlp_slot_free;
    assign req_fire      = req_valid && req_ready;
    assign len_ok        = (req_line_count != '0) && (req_line_count <= LC_W'(MAX_LINES));
    assign do_alloc      = req_fire && len_ok;
    assign do_bad_len    = req_fire && !len_ok;

    assign cpl_ready = !rsp_valid_q || rsp_ready;
    assign cpl_fire  = cpl_valid && cpl_ready;
    assign cpl_hit   = cpl_fire && in_use_q[cpl_tag];
    assign cpl_miss  = cpl_fire && !in_use_q[cpl_tag];
    assign cur_rx    = rx_count_q[cpl_tag];
    assign cur_lc    = line_count_q[cpl_tag];
    assign cpl_last  = (CMP_W'(cur_rx) + CMP_W'(1)) == CMP_W'(cur_lc);
    assign do_free   = cpl_hit && cpl_last;

    // Lowest-index free tag from the start-of-cycle occupancy
    always_comb begin
        alloc_tag = '0;
        for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
            if (!in_use_q[TAG_W'(i)]) begin
                alloc_tag = TAG_W'(i);
            end
        end
    end

    // Next-state for the TLP/response output registers, occupancy count and error flags
    always_comb begin
        tlp_valid_d      = tlp_valid_q;
        tlp_tag_d        = tlp_tag_q;
        tlp_line_count_d = tlp_line_count_q;
        tlp_addr_d       = tlp_addr_q;
        rsp_valid_d      = rsp_valid_q;
        rsp_afu_tag_d    = rsp_afu_tag_q;
        rsp_line_idx_d   = rsp_line_idx_q;
        rsp_last_d       = rsp_last_q;
        rsp_payload_d    = rsp_payload_q;
        busy_d           = busy_q + BUSY_W'(do_alloc) - BUSY_W'(do_free);
        err_bad_len_d    = err_bad_len_q || do_bad_len;
        err_unexp_cpl_d  = err_unexp_cpl_q || cpl_miss;

        if (do_alloc) begin
            tlp_valid_d      = 1'b1;
            tlp_tag_d        = alloc_tag;
            tlp_line_count_d = req_line_count;
            tlp_addr_d       = req_addr;
        end else if (tlp_ready) begin
            tlp_valid_d      = 1'b0;
        end

        if (cpl_hit) begin
            rsp_valid_d    = 1'b1;
            rsp_afu_tag_d  = afu_tag_q[cpl_tag];
            rsp_line_idx_d = IDX_W'(cur_rx);
            rsp_last_d     = cpl_last;
            rsp_payload_d  = cpl_payload;
        end else if (rsp_ready) begin
            rsp_valid_d    = 1'b0;
        end
    end

    // Output, counter and error-flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tlp_valid_q      <= 1'b0;
            tlp_tag_q        <= '0;
            tlp_line_count_q <= '0;
            tlp_addr_q       <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_afu_tag_q    <= '0;
            rsp_line_idx_q   <= '0;
            rsp_last_q       <= 1'b0;
            rsp_payload_q    <= '0;
            busy_q           <= '0;
            err_bad_len_q    <= 1'b0;
            err_unexp_cpl_q  <= 1'b0;
        end else begin
            tlp_valid_q      <= tlp_valid_d;
            tlp_tag_q        <= tlp_tag_d;
            tlp_line_count_q <= tlp_line_count_d;
            tlp_addr_q       <= tlp_addr_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_afu_tag_q    <= rsp_afu_tag_d;
            rsp_line_idx_q   <= rsp_line_idx_d;
            rsp_last_q       <= rsp_last_d;
            rsp_payload_q    <= rsp_payload_d;
            busy_q           <= busy_d;
            err_bad_len_q    <= err_bad_len_d;
            err_unexp_cpl_q  <= err_unexp_cpl_d;
        end
    end

    // Per-tag table: allocation targets a free tag, completion a busy one, so they never collide
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_use_q <= '0;
            for (int i = 0; i < int'(NUM_TAGS); i++) begin
                afu_tag_q[i]    <= '0;
                line_count_q[i] <= '0;
                rx_count_q[i]   <= '0;
            end
        end else begin
            if (do_alloc) begin
                in_use_q[alloc_tag]     <= 1'b1;
                afu_tag_q[alloc_tag]    <= req_afu_tag;
                line_count_q[alloc_tag] <= req_line_count;
                rx_count_q[alloc_tag]   <= '0;
            end
            if (cpl_hit) begin
                rx_count_q[cpl_tag] <= cur_rx + RX_W'(1);
                if (cpl_last) begin
                    in_use_q[cpl_tag] <= 1'b0;
                end
            end
        end
    end

    assign tlp_valid      = tlp_valid_q;
    assign tlp_tag        = tlp_tag_q;
    assign tlp_line_count = tlp_line_count_q;
    assign tlp_addr       = tlp_addr_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_afu_tag    = rsp_afu_tag_q;
    assign rsp_line_idx   = rsp_line_idx_q;
    assign rsp_last       = rsp_last_q;
    assign rsp_payload    = rsp_payload_q;
    assign busy_tags      = busy_q;
    assign err_bad_len    = err_bad_len_q;
    assign err_unexp_cpl  = err_unexp_cpl_q;

endmodule

// File: tb/tb_ofs_plat_host_chan_rd_tag_tracker.sv
// Self-checking bench for the read-tag tracker with a per-tag behavioural model.
module tb_ofs_plat_host_chan_rd_tag_tracker;

    localparam int unsigned NT = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned ML = 4;
    localparam int unsigned PW = 64;
    localparam int unsigned TW = 3;
    localparam int unsigned LW = 3;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_afu_tag;
    logic [LW-1:0] req_line_count;
    logic [63:0]   req_addr;
    logic          tlp_valid;
    logic          tlp_ready;
    logic [TW-1:0] tlp_tag;
    logic [LW-1:0] tlp_line_count;
    logic [63:0]   tlp_addr;
    logic          cpl_valid;
    logic          cpl_ready;
    logic [TW-1:0] cpl_tag;
    logic [PW-1:0] cpl_payload;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [AW-1:0] rsp_afu_tag;
    logic [IW-1:0] rsp_line_idx;
    logic          rsp_last;
    logic [PW-1:0] rsp_payload;
    logic [TW:0]   busy_tags;
    logic          err_bad_len;
    logic          err_unexp_cpl;

    int total = 0;
    int bad   = 0;

    // Reference model: which tags are outstanding and what each one owes
    bit            m_busy  [NT];
    logic [AW-1:0] m_afu   [NT];
    int            m_lines [NT];
    int            m_rx    [NT];
    bit            m_err_len;
    bit            m_err_cpl;

    always #5 clk = ~clk;

    ofs_plat_host_chan_rd_tag_tracker #(
        .NUM_TAGS(NT), .AFU_TAG_WIDTH(AW), .MAX_LINES(ML), .PAYLOAD_LINE_SIZE(PW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_afu_tag(req_afu_tag),
        .req_line_count(req_line_count), .req_addr(req_addr),
        .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_tag(tlp_tag),
        .tlp_line_count(tlp_line_count), .tlp_addr(tlp_addr),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag), .cpl_payload(cpl_payload),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_afu_tag(rsp_afu_tag),
        .rsp_line_idx(rsp_line_idx), .rsp_last(rsp_last), .rsp_payload(rsp_payload),
        .busy_tags(busy_tags), .err_bad_len(err_bad_len), .err_unexp_cpl(err_unexp_cpl)
    );

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NT; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NT; i++) begin
            m_busy[i] = 1'b0; m_rx[i] = 0; m_lines[i] = 0; m_afu[i] = '0;
        end
        m_err_len = 1'b0;
        m_err_cpl = 1'b0;
    endtask

    task automatic m_alloc(input int t, input logic [AW-1:0] afu, input int lc);
        m_busy[t] = 1'b1; m_afu[t] = afu; m_lines[t] = lc; m_rx[t] = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = {$urandom(), $urandom()};
        a[5:0] = 6'd0;
        return a;
    endfunction

    // One request cycle; checks handshake, TLP, busy count and length error
    task automatic do_req(input logic [AW-1:0] afu, input int lc, input logic [63:0] addr);
        int  exp_tag;
        bit  legal;
        bit  acc;
        exp_tag = m_lowest_free();
        legal   = (lc >= 1) && (lc <= ML);
        acc     = (exp_tag >= 0);
        req_valid = 1'b1; req_afu_tag = afu; req_line_count = LW'(lc); req_addr = addr;
        #1;
        total++;
        if (req_ready !== acc) begin bad++; $display("FAIL req_ready: got %b exp %b", req_ready, acc); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (acc && legal) m_alloc(exp_tag, afu, lc);
        if (acc && !legal) m_err_len = 1'b1;
        total++;
        if (tlp_valid !== (acc && legal)) begin bad++; $display("FAIL tlp_valid: got %b exp %b", tlp_valid, acc && legal); end
        if (acc && legal) begin
            total++;
            if (tlp_tag !== TW'(exp_tag)) begin bad++; $display("FAIL tlp_tag: got %0d exp %0d", tlp_tag, exp_tag); end
            total++;
            if (tlp_line_count !== LW'(lc)) begin bad++; $display("FAIL tlp_line_count: got %0d exp %0d", tlp_line_count, lc); end
            total++;
            if (tlp_addr !== addr) begin bad++; $display("FAIL tlp_addr: got %h exp %h", tlp_addr, addr); end
        end
        total++;
        if (err_bad_len !== m_err_len) begin bad++; $display("FAIL err_bad_len: got %b exp %b", err_bad_len, m_err_len); end
        total++;
        if (busy_tags !== (TW+1)'(m_count())) begin bad++; $display("FAIL busy_tags(req): got %0d exp %0d", busy_tags, m_count()); end
    endtask

    // One completion cycle; checks the response fields against the model
    task automatic do_cpl(input int t, input logic [PW-1:0] pay);
        bit hit;
        int exp_idx;
        bit exp_last;
        cpl_valid = 1'b1; cpl_tag = TW'(t); cpl_payload = pay;
        #1;
        total++;
        if (cpl_ready !== 1'b1) begin bad++; $display("FAIL cpl_ready: got %b exp 1", cpl_ready); end
        @(posedge clk); #1;
        cpl_valid = 1'b0;
        hit = m_busy[t];
        exp_idx = m_rx[t];
        exp_last = (m_rx[t] + 1 == m_lines[t]);
        if (hit) begin
            m_rx[t]++;
            if (exp_last) m_busy[t] = 1'b0;
        end else begin
            m_err_cpl = 1'b1;
        end
        total++;
        if (rsp_valid !== hit) begin bad++; $display("FAIL rsp_valid tag%0d: got %b exp %b", t, rsp_valid, hit); end
        if (hit) begin
            total++;
            if (rsp_afu_tag !== m_afu[t]) begin bad++; $display("FAIL rsp_afu_tag: got %h exp %h", rsp_afu_tag, m_afu[t]); end
            total++;
            if (rsp_line_idx !== IW'(exp_idx)) begin bad++; $display("FAIL rsp_line_idx: got %0d exp %0d", rsp_line_idx, exp_idx); end
            total++;
            if (rsp_last !== exp_last) begin bad++; $display("FAIL rsp_last: got %b exp %b", rsp_last, exp_last); end
            total++;
            if (rsp_payload !== pay) begin bad++; $display("FAIL rsp_payload: got %h exp %h", rsp_payload, pay); end
        end
        total++;
        if (err_unexp_cpl !== m_err_cpl) begin bad++; $display("FAIL err_unexp_cpl: got %b exp %b", err_unexp_cpl, m_err_cpl); end
        total++;
        if (busy_tags !== (TW+1)'(m_count())) begin bad++; $display("FAIL busy_tags(cpl): got %0d exp %0d", busy_tags, m_count()); end
        total++;
        if (tlp_valid !== 1'b0) begin bad++; $display("FAIL tlp_valid after cpl: got %b exp 0", tlp_valid); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 1'b0; req_afu_tag = '0; req_line_count = '0; req_addr = '0;
        tlp_ready = 1'b1;
        cpl_valid = 1'b0; cpl_tag = '0; cpl_payload = '0;
        rsp_ready = 1'b1;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        total++; if (tlp_valid !== 1'b0) begin bad++; $display("FAIL reset tlp_valid: got %b exp 0", tlp_valid); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset rsp_valid: got %b exp 0", rsp_valid); end
        total++; if (busy_tags !== '0) begin bad++; $display("FAIL reset busy_tags: got %0d exp 0", busy_tags); end
        total++; if (err_bad_len !== 1'b0) begin bad++; $display("FAIL reset err_bad_len: got %b exp 0", err_bad_len); end
        total++; if (err_unexp_cpl !== 1'b0) begin bad++; $display("FAIL reset err_unexp_cpl: got %b exp 0", err_unexp_cpl); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset req_ready: got %b exp 1", req_ready); end
        total++; if (cpl_ready !== 1'b1) begin bad++; $display("FAIL reset cpl_ready: got %b exp 1", cpl_ready); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_req(16'h1234, 4, 64'h1000);
        for (int l = 0; l < 4; l++) do_cpl(0, {$urandom(), $urandom()});
    endtask

    task automatic test_full_table();
        logic [PW-1:0] p;
        for (int i = 0; i < NT; i++) do_req(AW'($urandom()), 1, rand_addr());
        p = {$urandom(), $urandom()};
        req_valid = 1'b1; req_afu_tag = 16'hCAFE; req_line_count = LW'(1); req_addr = 64'h4_0000;
        cpl_valid = 1'b1; cpl_tag = TW'(3); cpl_payload = p;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full req_ready: got %b exp 0", req_ready); end
        @(posedge clk); #1;
        cpl_valid = 1'b0;
        m_busy[3] = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_last !== 1'b1 || rsp_afu_tag !== m_afu[3])
            begin bad++; $display("FAIL full rsp tag3: got v%b l%b %h exp v1 l1 %h", rsp_valid, rsp_last, rsp_afu_tag, m_afu[3]); end
        total++; if (busy_tags !== (TW+1)'(NT - 1)) begin bad++; $display("FAIL full busy after free: got %0d exp %0d", busy_tags, NT - 1); end
        total++; if (tlp_valid !== 1'b0) begin bad++; $display("FAIL full stalled tlp_valid: got %b exp 0", tlp_valid); end
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL full req_ready after free: got %b exp 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        m_alloc(3, 16'hCAFE, 1);
        total++; if (tlp_valid !== 1'b1 || tlp_tag !== TW'(3)) begin bad++; $display("FAIL full realloc: got v%b tag%0d exp v1 tag3", tlp_valid, tlp_tag); end
        total++; if (busy_tags !== (TW+1)'(NT)) begin bad++; $display("FAIL full busy realloc: got %0d exp %0d", busy_tags, NT); end
        for (int t = 0; t < NT; t++) do_cpl(t, {$urandom(), $urandom()});
    endtask

    task automatic test_interleave();
        do_req(16'hA000, 2, rand_addr());
        do_req(16'hA001, 2, rand_addr());
        do_cpl(1, {$urandom(), $urandom()});
        do_cpl(0, {$urandom(), $urandom()});
        do_cpl(1, {$urandom(), $urandom()});
        do_cpl(0, {$urandom(), $urandom()});
    endtask

    task automatic test_rsp_backpressure();
        int t;
        logic [PW-1:0] p0, p1;
        t = m_lowest_free();
        do_req(16'hBEEF, 2, rand_addr());
        p0 = {$urandom(), $urandom()};
        p1 = {$urandom(), $urandom()};
        rsp_ready = 1'b0;
        cpl_valid = 1'b1; cpl_tag = TW'(t); cpl_payload = p0;
        @(posedge clk); #1;
        m_rx[t] = 1;
        cpl_payload = p1;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (cpl_ready !== 1'b0) begin bad++; $display("FAIL bp cpl_ready cyc%0d: got %b exp 0", c, cpl_ready); end
            total++; if (rsp_valid !== 1'b1 || rsp_payload !== p0 || rsp_line_idx !== IW'(0) || rsp_last !== 1'b0)
                begin bad++; $display("FAIL bp rsp hold cyc%0d: got v%b %h idx%0d exp v1 %h idx0", c, rsp_valid, rsp_payload, rsp_line_idx, p0); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        total++; if (cpl_ready !== 1'b1) begin bad++; $display("FAIL bp cpl_ready release: got %b exp 1", cpl_ready); end
        @(posedge clk); #1;
        cpl_valid = 1'b0;
        m_rx[t] = 2; m_busy[t] = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_payload !== p1 || rsp_line_idx !== IW'(1) || rsp_last !== 1'b1)
            begin bad++; $display("FAIL bp second line: got v%b %h idx%0d l%b exp v1 %h idx1 l1", rsp_valid, rsp_payload, rsp_line_idx, rsp_last, p1); end
        total++; if (busy_tags !== (TW+1)'(m_count())) begin bad++; $display("FAIL bp busy: got %0d exp %0d", busy_tags, m_count()); end
    endtask

    task automatic test_tlp_backpressure();
        int ta, tb;
        logic [63:0] aa, ab;
        tick();
        aa = rand_addr(); ab = rand_addr();
        ta = m_lowest_free();
        tlp_ready = 1'b0;
        req_valid = 1'b1; req_afu_tag = 16'h5A5A; req_line_count = LW'(1); req_addr = aa;
        @(posedge clk); #1;
        m_alloc(ta, 16'h5A5A, 1);
        tb = m_lowest_free();
        req_afu_tag = 16'h6B6B; req_line_count = LW'(3); req_addr = ab;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL tbp req_ready cyc%0d: got %b exp 0", c, req_ready); end
            total++; if (tlp_valid !== 1'b1 || tlp_tag !== TW'(ta) || tlp_addr !== aa)
                begin bad++; $display("FAIL tbp hold cyc%0d: got v%b tag%0d %h exp v1 tag%0d %h", c, tlp_valid, tlp_tag, tlp_addr, ta, aa); end
            @(posedge clk); #1;
        end
        tlp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL tbp req_ready release: got %b exp 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        m_alloc(tb, 16'h6B6B, 3);
        total++; if (tlp_valid !== 1'b1 || tlp_tag !== TW'(tb) || tlp_addr !== ab || tlp_line_count !== LW'(3))
            begin bad++; $display("FAIL tbp second: got v%b tag%0d %h exp v1 tag%0d %h", tlp_valid, tlp_tag, tlp_addr, tb, ab); end
        do_cpl(ta, {$urandom(), $urandom()});
        for (int l = 0; l < 3; l++) do_cpl(tb, {$urandom(), $urandom()});
    endtask

    task automatic test_errors();
        do_req(16'h0BAD, 0, rand_addr());
        do_req(16'h0BAD, ML + 1, rand_addr());
        do_cpl(5, {$urandom(), $urandom()});
        do_req(16'h600D, 1, rand_addr());
        do_cpl(m_lowest_free() == 0 ? 0 : 0, {$urandom(), $urandom()});
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            int r;
            int pick;
            r = int'($urandom_range(0, 99));
            pick = -1;
            if (r >= 97) begin
                pick = int'($urandom_range(0, NT - 1));
            end else if (r < 45 || m_count() == 0) begin
                if (m_lowest_free() >= 0) begin
                    int lc;
                    lc = (r == 0) ? 0 : (r == 1) ? ML + 1 : (r == 2) ? 7 : int'($urandom_range(1, ML));
                    do_req(AW'($urandom()), lc, rand_addr());
                end
            end else begin
                int st;
                st = int'($urandom_range(0, NT - 1));
                for (int k = 0; k < NT; k++) begin
                    if (pick < 0 && m_busy[(st + k) % NT]) pick = (st + k) % NT;
                end
            end
            if (pick >= 0) do_cpl(pick, {$urandom(), $urandom()});
        end
    endtask

    task automatic test_reset_mid();
        if (m_lowest_free() >= 0) do_req(16'h7777, 3, rand_addr());
        if (m_lowest_free() >= 0) do_req(16'h8888, 2, rand_addr());
        req_valid = 1'b1; req_afu_tag = 16'h9999; req_line_count = LW'(2); req_addr = rand_addr();
        cpl_valid = 1'b1; cpl_tag = '0; cpl_payload = {$urandom(), $urandom()};
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (tlp_valid !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst valids: got tlp%b rsp%b exp 0 0", tlp_valid, rsp_valid); end
        total++; if (busy_tags !== '0) begin bad++; $display("FAIL midrst busy: got %0d exp 0", busy_tags); end
        total++; if (err_bad_len !== 1'b0 || err_unexp_cpl !== 1'b0) begin bad++; $display("FAIL midrst flags: got %b %b exp 0 0", err_bad_len, err_unexp_cpl); end
        total++; if (tlp_tag !== '0 || rsp_payload !== '0 || rsp_afu_tag !== '0) begin bad++; $display("FAIL midrst data: got %0d %h %h exp zero", tlp_tag, rsp_payload, rsp_afu_tag); end
        req_valid = 1'b0; cpl_valid = 1'b0;
        m_clear();
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();
        do_cpl(0, {$urandom(), $urandom()});
        do_req(16'h4242, 1, rand_addr());
        do_cpl(0, {$urandom(), $urandom()});
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_table();
        test_interleave();
        test_rsp_backpressure();
        test_tlp_backpressure();
        test_errors();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
